// File: rtl/mux16_scan_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux16_scan_serializer_if
//  Brief    : Handshake, mux and serial-stream bundle for the 16:1 mux
//             scan serializer. The slave modport is the serializer's view;
//             the master modport is the surrounding logic's view.
//  Revision : 1.0  initial release
// ============================================================================
interface mux16_scan_serializer_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [15:0] mux_data;
    logic [3:0]  mux_sel;
    logic        mux_y;
    logic        ser_valid;
    logic        ser_bit;
    logic        ser_last;
    logic        ser_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] out_word;

    modport slave (
        input  in_valid, in_data, mux_y, ser_ready,
        output in_ready, mux_data, mux_sel, ser_valid, ser_bit, ser_last,
               busy, done, err, out_word
    );

    modport master (
        output in_valid, in_data, mux_y, ser_ready,
        input  in_ready, mux_data, mux_sel, ser_valid, ser_bit, ser_last,
               busy, done, err, out_word
    );
endinterface
`default_nettype wire

// File: rtl/mux16_scan_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : mux16_scan_serializer
//  Brief    : Accepts a 16-bit word, holds it on the mux data bus and steps
//             the mux select through all 16 positions, streaming each mux
//             output bit with backpressure. Returned bits are reassembled
//             and compared against the launched word (loop-back check).
//  Revision : 1.0  initial release
// ============================================================================
module mux16_scan_serializer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  wire logic               clk,
    input  wire logic               rst,
    mux16_scan_serializer_if.slave  bus
);

    localparam logic [3:0] c_first_sel = MSB_FIRST ? 4'd15 : 4'd0;
    localparam logic [3:0] c_last_sel  = MSB_FIRST ? 4'd0  : 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_mux_data;
    logic [3:0]  r_mux_sel;
    logic [15:0] r_rebuild;
    logic [15:0] r_out_word;
    logic        r_mism;
    logic        r_in_ready;
    logic        r_ser_valid;
    logic        r_ser_last;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic [15:0] w_rebuild_next;
    logic [3:0]  w_sel_next;
    logic        w_bit_mism;

    // Returned bit disagrees with the bit launched on the selected position.
    assign w_bit_mism = bus.mux_y ^ r_mux_data[r_mux_sel];
    assign w_sel_next = MSB_FIRST ? (r_mux_sel - 4'd1) : (r_mux_sel + 4'd1);

    // Rebuilt word including the bit returned this cycle, so the last beat
    // lands in out_word together with the done pulse.
    always_comb begin
        w_rebuild_next            = r_rebuild;
        w_rebuild_next[r_mux_sel] = bus.mux_y;
    end

    // Frame control FSM; all handshake and status outputs are registered.
    // r_ser_last tracks (mux_sel == last index) and is only high in SCAN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mux_data  <= 16'h0000;
            r_mux_sel   <= 4'd0;
            r_rebuild   <= 16'h0000;
            r_out_word  <= 16'h0000;
            r_mism      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_mux_data  <= bus.in_data;
                        r_mux_sel   <= c_first_sel;
                        r_rebuild   <= 16'h0000;
                        r_mism      <= 1'b0;
                        r_in_ready  <= 1'b0;
                        r_ser_valid <= 1'b1;
                        r_ser_last  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // Stalled beats hold select, data and status untouched.
                    if (bus.ser_ready) begin
                        r_rebuild <= w_rebuild_next;
                        r_mism    <= r_mism | w_bit_mism;
                        if (r_ser_last) begin
                            r_ser_valid <= 1'b0;
                            r_ser_last  <= 1'b0;
                            r_done      <= 1'b1;
                            r_err       <= r_mism | w_bit_mism;
                            r_out_word  <= w_rebuild_next;
                            r_state     <= ST_DONE;
                        end else begin
                            r_mux_sel  <= w_sel_next;
                            r_ser_last <= (w_sel_next == c_last_sel);
                        end
                    end
                end
                ST_DONE: begin
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_ser_valid <= 1'b0;
                    r_ser_last  <= 1'b0;
                    r_done      <= 1'b0;
                    r_err       <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.mux_data  = r_mux_data;
    assign bus.mux_sel   = r_mux_sel;
    assign bus.ser_valid = r_ser_valid;
    assign bus.ser_bit   = bus.mux_y;
    assign bus.ser_last  = r_ser_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.out_word  = r_out_word;

endmodule
`default_nettype wire

// File: tb/tb_mux16_scan_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux16_scan_serializer
//  Brief    : Scoreboard bench for mux16_scan_serializer, with an LSB-first
//             and an MSB-first instance sharing clock and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux16_scan_serializer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    bit   bp_mode = 1'b0;
    bit   fault_a = 1'b0;

    mux16_scan_serializer_if ifa ();
    mux16_scan_serializer_if ifb ();

    mux16_scan_serializer #(.MSB_FIRST(1'b0)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    mux16_scan_serializer #(.MSB_FIRST(1'b1)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    always #5 clk = ~clk;

    // Cycle index; updated with NBA so the DUT samples a stable ser_ready.
    always @(posedge clk) cyc <= cyc + 1;

    // External mux models; the A model can force a stuck-at-1 on select 7.
    assign ifa.mux_y     = ifa.mux_data[ifa.mux_sel] | (fault_a && (ifa.mux_sel == 4'd7));
    assign ifb.mux_y     = ifb.mux_data[ifb.mux_sel];
    assign ifa.ser_ready = bp_mode ? cyc[0] : 1'b1;
    assign ifb.ser_ready = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // ---------------------------------------------------------------- scoreboard
    logic [4:0]  exp_b_a[$];   // {sel, bit}
    logic [16:0] exp_w_a[$];   // {err, word}
    logic [4:0]  exp_b_b[$];
    logic [16:0] exp_w_b[$];
    logic [4:0]  e_a, e_b;
    logic [16:0] w_a, w_b;
    int          acc_a = 0, stalls_a = 0, beats_a = 0, beats_b = 0;
    int          last_lat_a = 0;
    logic [15:0] last_out_a = '0, last_out_b = '0;
    logic        last_err_a = 1'b0, last_err_b = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (ifa.in_valid && ifa.in_ready) begin
                for (int i = 0; i < 16; i++)
                    exp_b_a.push_back({4'(i), (fault_a && i == 7) ? 1'b1 : ifa.in_data[i]});
                exp_w_a.push_back({fault_a && !ifa.in_data[7],
                                   ifa.in_data | (fault_a ? 16'h0080 : 16'h0000)});
                acc_a = cyc; stalls_a = 0; beats_a = 0;
            end
            if (ifa.ser_valid) begin
                if (ifa.ser_ready) begin
                    if (exp_b_a.size() == 0) check("a_beat_unexpected", 1, 0);
                    else begin
                        e_a = exp_b_a.pop_front();
                        check("a_sel", ifa.mux_sel, e_a[4:1]);
                        check("a_bit", ifa.ser_bit, e_a[0]);
                        check("a_last", ifa.ser_last, beats_a == 15);
                    end
                    beats_a++;
                end else stalls_a++;
            end
            if (ifa.done) begin
                if (exp_w_a.size() == 0) check("a_done_unexpected", 1, 0);
                else begin
                    w_a = exp_w_a.pop_front();
                    check("a_out_word", ifa.out_word, w_a[15:0]);
                    check("a_err", ifa.err, w_a[16]);
                    check("a_done_lat", cyc - acc_a, 17 + stalls_a);
                end
                last_lat_a = cyc - acc_a;
                last_out_a = ifa.out_word;
                last_err_a = ifa.err;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ifb.in_valid && ifb.in_ready) begin
                for (int i = 0; i < 16; i++)
                    exp_b_b.push_back({4'(15 - i), ifb.in_data[15 - i]});
                exp_w_b.push_back({1'b0, ifb.in_data});
                beats_b = 0;
            end
            if (ifb.ser_valid && ifb.ser_ready) begin
                if (exp_b_b.size() == 0) check("b_beat_unexpected", 1, 0);
                else begin
                    e_b = exp_b_b.pop_front();
                    check("b_sel", ifb.mux_sel, e_b[4:1]);
                    check("b_bit", ifb.ser_bit, e_b[0]);
                    check("b_last", ifb.ser_last, beats_b == 15);
                end
                beats_b++;
            end
            if (ifb.done) begin
                if (exp_w_b.size() == 0) check("b_done_unexpected", 1, 0);
                else begin
                    w_b = exp_w_b.pop_front();
                    check("b_out_word", ifb.out_word, w_b[15:0]);
                    check("b_err", ifb.err, w_b[16]);
                end
                last_out_b = ifb.out_word;
                last_err_b = ifb.err;
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    // Offer a word until accepted; 'odd' aligns acceptance to an odd cycle so
    // the alternating ser_ready pattern starts with a stall.
    task automatic send(input bit which, input logic [15:0] w, input bit odd, output int ta);
        bit got = 1'b0;
        ta = 0;
        @(posedge clk); #1;
        if (odd && cyc[0] == 1'b0) begin @(posedge clk); #1; end
        if (which) begin ifb.in_valid = 1'b1; ifb.in_data = w; end
        else       begin ifa.in_valid = 1'b1; ifa.in_data = w; end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (which ? ifb.in_ready : ifa.in_ready) begin got = 1'b1; ta = cyc; break; end
        end
        if (!got) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        if (which) ifb.in_valid = 1'b0; else ifa.in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit which);
        bit got = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (which ? ifb.done : ifa.done) begin got = 1'b1; break; end
        end
        if (!got) check("done_timeout", 0, 1);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, ifa.in_ready, 1);
        check({tag, "_busy"},     ifa.busy, 0);
        check({tag, "_ser_valid"}, ifa.ser_valid, 0);
        check({tag, "_ser_last"}, ifa.ser_last, 0);
        check({tag, "_done"},     ifa.done, 0);
        check({tag, "_err"},      ifa.err, 0);
        check({tag, "_mux_data"}, ifa.mux_data, 0);
        check({tag, "_mux_sel"},  ifa.mux_sel, 0);
        check({tag, "_out_word"}, ifa.out_word, 0);
    endtask

    // ---------------------------------------------------------------- directed flow
    initial begin
        int ta, t1, t2;
        bit got;
        ifa.in_valid = 1'b0; ifa.in_data = 16'h0000;
        ifb.in_valid = 1'b0; ifb.in_data = 16'h0000;
        #1 rst = 1'b1;
        #1 check_reset_values("rst0");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // LSB-first nominal frame and its exact timing.
        send(1'b0, 16'hA5C3, 1'b0, ta);
        wait_done(1'b0);
        check("t1_done_lat", last_lat_a, 17);
        check("t1_out_word", last_out_a, 16'hA5C3);
        check("t1_err", last_err_a, 0);
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ifa.in_ready) begin got = 1'b1; break; end
        end
        check("t1_ready_found", got, 1);
        check("t1_ready_lat", cyc - ta, 18);

        // MSB-first frame.
        send(1'b1, 16'h8001, 1'b0, ta);
        wait_done(1'b1);
        check("t2_out_word", last_out_b, 16'h8001);
        check("t2_err", last_err_b, 0);
        check("t2_beats", beats_b, 16);

        // Backpressure: ser_ready low every other cycle, starting with a stall.
        bp_mode = 1'b1;
        send(1'b0, 16'hFFFF, 1'b1, ta);
        wait_done(1'b0);
        bp_mode = 1'b0;
        check("t3_done_lat", last_lat_a, 33);
        check("t3_out_word", last_out_a, 16'hFFFF);
        check("t3_stalls", stalls_a, 16);

        // Stuck-at-1 on select 7.
        fault_a = 1'b1;
        send(1'b0, 16'h0000, 1'b0, ta);
        wait_done(1'b0);
        fault_a = 1'b0;
        check("t4_err", last_err_a, 1);
        check("t4_out_word", last_out_a, 16'h0080);

        // in_valid held through a frame: second word waits for in_ready.
        @(posedge clk); #1;
        ifa.in_valid = 1'b1; ifa.in_data = 16'h5678;
        got = 1'b0; t1 = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ifa.in_ready) begin got = 1'b1; t1 = cyc; break; end
        end
        @(posedge clk); #1;
        ifa.in_data = 16'h1234;
        t2 = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ifa.in_ready) begin got = got & 1'b1; t2 = cyc; break; end
        end
        check("t5_second_accept_gap", t2 - t1, 18);
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        wait_done(1'b0);
        check("t5_out_word", last_out_a, 16'h1234);

        // Reset during the sixth beat aborts the frame immediately.
        send(1'b0, 16'hBEEF, 1'b0, ta);
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (beats_a == 6) begin got = 1'b1; break; end
        end
        check("t6_reached_beat6", got, 1);
        rst = 1'b1;
        #1 check_reset_values("t6_rst");
        exp_b_a.delete(); exp_w_a.delete(); beats_a = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(1'b0, 16'h00FF, 1'b0, ta);
        wait_done(1'b0);
        check("t6_out_word", last_out_a, 16'h00FF);
        check("t6_err", last_err_a, 0);
        check("t6_done_lat", last_lat_a, 17);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain_a", exp_b_a.size() + exp_w_a.size(), 0);
        check("sb_drain_b", exp_b_b.size() + exp_w_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        check("watchdog", 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mux16_scan_serializer.md
# mux16_scan_serializer

Sequential front-end for the 16:1 mux datapath. The block accepts a 16-bit word over a valid/ready handshake, holds it on the mux data bus, and steps the 4-bit mux select through all 16 positions. Each selected mux output bit is forwarded as a serial stream with backpressure. The returned bits are also reassembled into a word and checked against the launched word, giving a loop-back integrity check of the mux tree.

## Interface
Parameters:
- MSB_FIRST, default 0, scan order: 0 = select 0→15, 1 = select 15→0

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream word valid
- in_data  in  16  upstream word
- in_ready  out  1  block can accept a word (high only in IDLE)
- mux_data  out  16  registered word driven onto the mux data inputs
- mux_sel  out  4  registered select driven onto the mux select inputs
- mux_y  in  1  combinational output returned from the mux
- ser_valid  out  1  serial bit valid (high only in SCAN)
- ser_bit  out  1  serial bit, equal to mux_y
- ser_last  out  1  current bit is the 16th of the frame
- ser_ready  in  1  downstream accepts the serial bit
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle pulse at frame end
- err  out  1  valid with done: at least one returned bit mismatched
- out_word  out  16  reassembled word, updated in DONE and held until the next DONE

## Operation
The FSM has three states: IDLE, SCAN, DONE.

IDLE:
- in_ready=1.
- On in_valid: mux_data<=in_data; mux_sel<=0, or 15 when MSB_FIRST=1; rebuild<=0; mism<=0; go to SCAN.

SCAN:
- ser_valid=1, ser_bit=mux_y, ser_last=(mux_sel==last index).
- On ser_valid&&ser_ready (a beat):
  - rebuild[mux_sel]<=mux_y.
  - mism<=mism|(mux_y!=mux_data[mux_sel]).
  - If ser_last, go to DONE; otherwise step mux_sel by +1, or −1 when MSB_FIRST=1.
- While ser_ready=0: mux_sel, mux_data and ser_bit hold; no state change.

DONE:
- done=1; err = the final mism, including the last beat's compare; out_word <= final rebuild.
- Return to IDLE on the next clock.
- in_ready=0.

General rules:
- mux_data is constant for the entire frame and changes only on acceptance.
- in_valid is ignored outside IDLE; words are neither lost nor queued, because in_ready=0.
- Select arithmetic is 4-bit. The frame always terminates at the last index, so no wrap occurs inside a frame.
- ser_bit is a combinational pass-through of mux_y. The external mux must settle within one cycle of a mux_sel/mux_data update.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State is IDLE.
  - mux_data=0, mux_sel=0, out_word=0; done, err, busy, ser_valid, ser_last = 0.
  - in_ready=1 once in IDLE.
- Reset asserted mid-frame: the frame is aborted, no done pulse, out_word is cleared to 0, and the serial stream stops the same cycle.
- Acceptance in cycle T, with ser_ready held at 1:
  - ser_valid at T+1..T+16; ser_last at T+16.
  - done/err at T+17.
  - in_ready back at T+18.
  - Minimum frame period: 18 cycles.
- Each low cycle on ser_ready extends the frame by one cycle. A bit is never skipped or duplicated.
- ser_ready is ignored outside SCAN.
- in_valid and ser_ready may both be high in the same cycle in any state. Only the signal belonging to the current state has effect.

## Test plan
- LSB-first, ser_ready=1, in_data=16'hA5C3:
  - Serial bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - ser_last on the 16th bit; done at T+17; err=0; out_word=16'hA5C3.
- MSB_FIRST=1, in_data=16'h8001: bits 1, then fourteen 0s, then 1; mux_sel runs 15→0; out_word=16'h8001.
- Backpressure, in_data=16'hFFFF, ser_ready low every other cycle: 16 beats, done at T+33, mux_sel held during stalls.
- Fault injection, in_data=16'h0000, mux_y forced to 1 when mux_sel==7: err=1 with done; out_word=16'h0080.
- in_valid with 16'h1234 held during a frame of 16'h5678: only 16'h5678 is emitted; 16'h1234 is accepted the cycle in_ready returns.
- rst asserted at the 6th beat of a frame: all outputs are at their reset values immediately, no done; the next word 16'h00FF completes normally.
